cpu_cycle_sequencer: RTL

//  Multi-cycle controller for the ARM_processor datapath.

---
 rtl/cpu_cycle_sequencer_if.sv | 46 ++++
 rtl/cpu_cycle_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_cycle_sequencer_if
// Description : Decode, memory handshake, debug request and enable bundle
//               between the cycle sequencer and the ARM datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_cycle_sequencer_if #(
   parameter int unsigned CNT_W = 32
);
   logic [1:0]       type_code;
   logic             load_bit;
   logic             should_store_link;
   logic             write_condition;
   logic             mem_ready;
   logic             halt_req;
   logic             resume_req;
   logic             step_req;

   logic             ir_load;
   logic             cpsr_update_en;
   logic             dmem_read_en;
   logic             dmem_write_en;
   logic             regfile_write_en;
   logic             pc_enable;
   logic             halted;
   logic             bus_error;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_count;

   // master is the sequencer, slave is the datapath / debug side
   modport master (
      input  type_code, load_bit, should_store_link, write_condition,
      input  mem_ready, halt_req, resume_req, step_req,
      output ir_load, cpsr_update_en, dmem_read_en, dmem_write_en,
      output regfile_write_en, pc_enable, halted, bus_error, state, instr_count
   );

   modport slave (
      output type_code, load_bit, should_store_link, write_condition,
      output mem_ready, halt_req, resume_req, step_req,
      input  ir_load, cpsr_update_en, dmem_read_en, dmem_write_en,
      input  regfile_write_en, pc_enable, halted, bus_error, state, instr_count
   );
endinterface
`default_nettype wire

// File: rtl/cpu_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_cycle_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller
//               with memory wait states, timeout, halt and single-step.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_cycle_sequencer #(
   parameter int unsigned FETCH_WAIT  = 1,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  wire logic             clock,
   input  wire logic             reset,
   cpu_cycle_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_t;

   localparam logic [2:0] FETCH_LAST = 3'(FETCH_WAIT);
   localparam logic [7:0] MEM_LAST   = 8'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [2:0]       wcnt_q, wcnt_d;
   logic [7:0]       tcnt_q, tcnt_d;
   logic             step_pending_q, step_pending_d;
   logic             bus_error_q, bus_error_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;

   logic is_mem_op;
   logic rf_wr_cond;
   logic ir_load_w, cpsr_update_en_w, dmem_read_en_w, dmem_write_en_w;
   logic regfile_write_en_w, pc_enable_w, halted_w;

   assign is_mem_op  = (bus.type_code == 2'b00) && bus.write_condition;
   assign rf_wr_cond = bus.write_condition &
                       ((bus.type_code == 2'b01) |
                        ((bus.type_code == 2'b00) & bus.load_bit) |
                        ((bus.type_code == 2'b10) & bus.should_store_link));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_FETCH;
         wcnt_q         <= '0;
         tcnt_q         <= '0;
         step_pending_q <= 1'b0;
         bus_error_q    <= 1'b0;
         instr_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         tcnt_q         <= tcnt_d;
         step_pending_q <= step_pending_d;
         bus_error_q    <= bus_error_d;
         instr_count_q  <= instr_count_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wcnt_d         = wcnt_q;
      tcnt_d         = tcnt_q;
      step_pending_d = step_pending_q;
      bus_error_d    = bus_error_q;
      instr_count_d  = instr_count_q;
      case (state_q)
         ST_FETCH: begin
            if (wcnt_q == FETCH_LAST) begin
               wcnt_d  = '0;
               state_d = ST_DECODE;
            end else begin
               wcnt_d = wcnt_q + 3'd1;
            end
         end
         ST_DECODE: state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            if (is_mem_op) begin
               tcnt_d  = '0;
               state_d = ST_MEMORY;
            end else begin
               state_d = ST_WRITEBACK;
            end
         end
         ST_MEMORY: begin
            // A timed-out access is abandoned without any register or PC commit
            if (bus.mem_ready) begin
               state_d = ST_WRITEBACK;
            end else if (tcnt_q == MEM_LAST) begin
               bus_error_d = 1'b1;
               state_d     = ST_HALT;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         ST_WRITEBACK: begin
            instr_count_d = instr_count_q + CNT_W'(1);
            if (bus.halt_req || step_pending_q || bus_error_q) begin
               step_pending_d = 1'b0;
               state_d        = ST_HALT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
            // halt_req dominates; a bus error pins the core here until reset
            if (!bus_error_q && !bus.halt_req) begin
               if (bus.step_req) begin
                  step_pending_d = 1'b1;
                  state_d        = ST_FETCH;
               end else if (bus.resume_req) begin
                  step_pending_d = 1'b0;
                  state_d        = ST_FETCH;
               end
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      ir_load_w          = 1'b0;
      cpsr_update_en_w   = 1'b0;
      dmem_read_en_w     = 1'b0;
      dmem_write_en_w    = 1'b0;
      regfile_write_en_w = 1'b0;
      pc_enable_w        = 1'b0;
      halted_w           = 1'b0;
      case (state_q)
         ST_FETCH:     ir_load_w = (wcnt_q == FETCH_LAST);
         ST_EXECUTE:   cpsr_update_en_w = 1'b1;
         ST_MEMORY: begin
            dmem_read_en_w  = bus.load_bit;
            dmem_write_en_w = ~bus.load_bit;
         end
         ST_WRITEBACK: begin
            pc_enable_w        = 1'b1;
            regfile_write_en_w = rf_wr_cond;
         end
         ST_HALT:      halted_w = 1'b1;
         default:      halted_w = 1'b0;
      endcase
      // No strobe may escape while reset is held, even with FETCH_WAIT == 0
      if (!reset) begin
         ir_load_w          = 1'b0;
         cpsr_update_en_w   = 1'b0;
         dmem_read_en_w     = 1'b0;
         dmem_write_en_w    = 1'b0;
         regfile_write_en_w = 1'b0;
         pc_enable_w        = 1'b0;
      end
   end

   assign bus.ir_load          = ir_load_w;
   assign bus.cpsr_update_en   = cpsr_update_en_w;
   assign bus.dmem_read_en     = dmem_read_en_w;
   assign bus.dmem_write_en    = dmem_write_en_w;
   assign bus.regfile_write_en = regfile_write_en_w;
   assign bus.pc_enable        = pc_enable_w;
   assign bus.halted           = halted_w;
   assign bus.bus_error        = bus_error_q;
   assign bus.state            = state_q;
   assign bus.instr_count      = instr_count_q;

endmodule
`default_nettype wire
